// File: rtl/aes_frame_responder.sv
// aes_frame_responder
//    Responder end of the 16-byte key/block/result exchange behind an SPI slave.
//    Collects NBYTES key bytes, then repeatedly collects NBYTES block bytes, waits
//    CIPHER_LATENCY cycles for the attached cipher/inv_cipher, and then shifts the
//    result back out one byte per received (dummy) byte.
//
//    state  | meaning
//    S_KEY  | loading key bytes, tx_byte = 00
//    S_DATA | loading block bytes, tx_byte = 00
//    S_WAIT | block complete, waiting for the combinational cipher to settle
//    S_SEND | presenting result bytes, one per rx_valid
//
// Ports
//    clk        in   system clock, rising edge
//    reset      in   synchronous active-high reset
//    rx_valid   in   one-cycle pulse per completed SPI byte
//    rx_byte    in   received byte, valid with rx_valid
//    new_key    in   abandon current frame and go back to key loading
//    result     in   cipher output
//    tx_byte    out  byte for the slave's next transfer
//    key        out  assembled key (byte 0 in the MSBs)
//    block      out  assembled data block (byte 0 in the MSBs)
//    busy       out  frame in progress
//    frame_done out  one-cycle pulse after the last result byte is consumed
module aes_frame_responder #(
   parameter int NBYTES         = 16,
   parameter int CIPHER_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_byte,
   input  logic                  new_key,
   input  logic [NBYTES*8-1:0]   result,
   output logic [7:0]            tx_byte,
   output logic [NBYTES*8-1:0]   key,
   output logic [NBYTES*8-1:0]   block,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int W  = NBYTES * 8;
   localparam int WW = (CIPHER_LATENCY > 1) ? $clog2(CIPHER_LATENCY) : 1;
   localparam logic [3:0]    CNT_LAST  = 4'(NBYTES - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(CIPHER_LATENCY - 1);

   typedef enum logic [1:0] {S_KEY, S_DATA, S_WAIT, S_SEND} state_t;

   state_t        state_q;
   logic [3:0]    cnt_q;
   logic [WW-1:0] wcnt_q;
   logic [W-1:0]  key_q;
   logic [W-1:0]  block_q;
   logic [W-1:0]  res_q;
   logic [7:0]    tx_q;
   logic          done_q;

   logic          cnt_last;
   logic [3:0]    cnt_inc;

   assign cnt_last = (cnt_q == CNT_LAST);
   assign cnt_inc  = cnt_last ? 4'd0 : cnt_q + 4'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_KEY;
         cnt_q   <= '0;
         wcnt_q  <= '0;
         key_q   <= '0;
         block_q <= '0;
         res_q   <= '0;
         tx_q    <= 8'h00;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // new_key overrides everything, including a byte arriving this cycle;
         // key/block/res_q keep whatever was already written.
         if (new_key) begin
            state_q <= S_KEY;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            tx_q    <= 8'h00;
         end else begin
            case (state_q)
               S_KEY: begin
                  if (rx_valid) begin
                     key_q[8*(NBYTES-1-int'(cnt_q)) +: 8] <= rx_byte;
                     cnt_q <= cnt_inc;
                     if (cnt_last) state_q <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (rx_valid) begin
                     block_q[8*(NBYTES-1-int'(cnt_q)) +: 8] <= rx_byte;
                     cnt_q <= cnt_inc;
                     if (cnt_last) begin
                        state_q <= S_WAIT;
                        wcnt_q  <= '0;
                     end
                  end
               end
               S_WAIT: begin
                  wcnt_q <= wcnt_q + 1'b1;
                  if (wcnt_q == WAIT_LAST) begin
                     res_q   <= result;
                     tx_q    <= result[W-1 -: 8];
                     state_q <= S_SEND;
                  end
               end
               S_SEND: begin
                  // incoming byte is dummy data from the master and is dropped
                  if (rx_valid) begin
                     cnt_q <= cnt_inc;
                     if (cnt_last) begin
                        tx_q    <= 8'h00;
                        done_q  <= 1'b1;
                        state_q <= S_DATA;
                     end else begin
                        tx_q <= res_q[8*(NBYTES-1-int'(cnt_inc)) +: 8];
                     end
                  end
               end
               default: state_q <= S_KEY;
            endcase
         end
      end
   end

   assign tx_byte    = tx_q;
   assign key        = key_q;
   assign block      = block_q;
   assign frame_done = done_q;
   assign busy       = (state_q == S_WAIT) || (state_q == S_SEND) || (cnt_q != 4'd0);

endmodule

// File: tb/tb_aes_frame_responder.sv
// Directed bench for aes_frame_responder. The cipher is not instantiated; the
// bench drives the known AES-128 result for each block onto 'result'.
module tb_aes_frame_responder;

   logic         clk = 1'b0;
   logic         reset;
   logic         rx_valid;
   logic [7:0]   rx_byte;
   logic         new_key;
   logic [127:0] result;
   logic [7:0]   tx_byte;
   logic [127:0] key;
   logic [127:0] block;
   logic         busy;
   logic         frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   aes_frame_responder #(.NBYTES(16), .CIPHER_LATENCY(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_byte    (rx_byte),
      .new_key    (new_key),
      .result     (result),
      .tx_byte    (tx_byte),
      .key        (key),
      .block      (block),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
      return v[8*(15-i) +: 8];
   endfunction

   // drive at negedge, DUT captures at the following posedge, outputs read at next negedge
   task automatic put(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
   endtask

   task automatic send_word(input logic [127:0] w);
      for (int i = 0; i < 16; i++) put(byte_of(w, i));
   endtask

   // after the last block byte: wait out the cipher latency, then read the result back
   task automatic read_result(input logic [127:0] exp, input string tag);
      check_val({tag, " wait busy"}, 128'(busy), 128'(1'b1));
      @(negedge clk);
      check_val({tag, " early tx"}, 128'(tx_byte), 128'h00);
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         check_val($sformatf("%s tx%0d", tag, i), 128'(tx_byte), 128'(byte_of(exp, i)));
         check_val($sformatf("%s nodone%0d", tag, i), 128'(frame_done), 128'(1'b0));
         put(8'hA5);
      end
      check_val({tag, " done"}, 128'(frame_done), 128'(1'b1));
      check_val({tag, " tx idle"}, 128'(tx_byte), 128'h00);
      check_val({tag, " busy idle"}, 128'(busy), 128'(1'b0));
      @(negedge clk);
      check_val({tag, " done once"}, 128'(frame_done), 128'(1'b0));
   endtask

   initial begin
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      new_key  = 1'b0;
      result   = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_val("rst key", key, '0);
      check_val("rst block", block, '0);
      check_val("rst tx", 128'(tx_byte), 128'h00);
      check_val("rst busy", 128'(busy), 128'(1'b0));
      check_val("rst done", 128'(frame_done), 128'(1'b0));

      // key load, back-to-back bytes
      for (int i = 0; i < 16; i++) begin
         put(byte_of(KEY1, i));
         if (i == 0) check_val("key busy", 128'(busy), 128'(1'b1));
      end
      check_val("key1", key, KEY1);
      check_val("key busy end", 128'(busy), 128'(1'b0));

      // encrypt frame
      result = CT1;
      send_word(PT1);
      check_val("block1", block, PT1);
      read_result(CT1, "enc");
      check_val("key kept", key, KEY1);

      // second frame without key reload, inverse direction
      result = PT1;
      send_word(CT1);
      check_val("block2", block, CT1);
      read_result(PT1, "dec");
      check_val("key kept2", key, KEY1);

      // new_key collides with block byte 7
      for (int i = 0; i < 7; i++) put(byte_of(PT1, i));
      rx_valid = 1'b1;
      rx_byte  = byte_of(PT1, 7);
      new_key  = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      new_key  = 1'b0;
      check_val("nk busy", 128'(busy), 128'(1'b0));
      check_val("nk tx", 128'(tx_byte), 128'h00);
      check_val("nk block", block, {PT1[127:72], CT1[71:0]});
      check_val("nk key", key, KEY1);
      send_word(KEY2);
      check_val("key2", key, KEY2);
      result = CT2;
      send_word(PT2);
      check_val("block3", block, PT2);
      read_result(CT2, "enc2");

      // reset in the middle of sending
      result = CT1;
      send_word(PT1);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) put(8'h00);
      check_val("pre-rst tx", 128'(tx_byte), 128'(byte_of(CT1, 5)));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_val("mid rst tx", 128'(tx_byte), 128'h00);
      check_val("mid rst key", key, '0);
      check_val("mid rst done", 128'(frame_done), 128'(1'b0));
      check_val("mid rst busy", 128'(busy), 128'(1'b0));
      send_word(KEY1);
      check_val("key reload", key, KEY1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
